// File: rtl/regfile_dump_streamer_pkg.sv
// Shared definitions for the register-file dump streamer: default sizing and
// the FSM state encoding. Encoding 2'd3 is unused and recovers to IDLE.
package regfile_dump_streamer_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_dump_streamer.sv
// Register-file dump streamer. On a start pulse, walks RF read addresses
// 0..NUM_REGS-1 through one combinational read port and streams every word
// out over valid/ready, tagged with its index and a last flag. hold_wb is
// high for the whole dump so writeback stalls and the dump is a snapshot.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      synchronous reset, active-low
//   start      dump request, sampled only in IDLE
//   rd_addr    RF read address (combinational read)
//   rd_data    RF read data for rd_addr, same cycle
//   hold_wb    stall RF writes while high
//   out_valid / out_ready / out_data / out_index / out_last   stream port
//   busy       high in FETCH/SEND
//   done       one-cycle pulse after the last word is accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done pulses here for one cycle after a dump
// FETCH | one cycle, captures word 0 from the RF into the output register
// SEND  | output register valid; each handshake loads the next word
module regfile_dump_streamer
  import regfile_dump_streamer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hold_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // ptr is one bit wider than the address so NUM_REGS == 2**ADDR_W can be
  // represented as the end-of-dump value without wrapping to 0.
  localparam logic [ADDR_W:0] PTR_END  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  state_t              state, state_nx;
  logic [ADDR_W:0]     ptr, ptr_nx;
  logic                valid_nx, last_nx, done_nx;
  logic [DATA_W-1:0]   data_nx;
  logic [ADDR_W-1:0]   index_nx;
  logic                handshake;

  assign handshake = out_valid & out_ready;
  assign rd_addr   = ptr[ADDR_W-1:0];
  assign busy      = (state != ST_IDLE);
  assign hold_wb   = busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      out_index <= index_nx;
      out_last  <= last_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    valid_nx = out_valid;
    data_nx  = out_data;
    index_nx = out_index;
    last_nx  = out_last;
    done_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          ptr_nx   = '0;
          state_nx = ST_FETCH;
        end
      end

      ST_FETCH: begin
        data_nx  = rd_data;
        index_nx = '0;
        last_nx  = (NUM_REGS == 1);
        valid_nx = 1'b1;
        ptr_nx   = PTR_ONE;
        state_nx = ST_SEND;
      end

      ST_SEND: begin
        // Without a handshake everything holds, so the word never retracts.
        if (handshake) begin
          if (ptr < PTR_END) begin
            data_nx  = rd_data;
            index_nx = ptr[ADDR_W-1:0];
            last_nx  = (ptr == PTR_LAST);
            ptr_nx   = ptr + PTR_ONE;
          end else begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
